// File: rtl/gray_counter_pkg.sv
// Registered Gray-code counter with a binary shadow.
// The counter keeps a binary state and a registered Gray copy of it. It
// counts up or down, loads from a binary or Gray value, and either wraps
// or saturates at the ends.
// Optional build macro: GRAY_CNT_CHECK_EN adds an 'err' output that flags
// a Gray register that has lost one-bit stepping or its match with the
// binary state.
module gray_counter_pkg #(
    parameter int unsigned        WIDTH     = 4,
    parameter int unsigned        WRAP      = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             at_limit
`ifdef GRAY_CNT_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL    = '1;
    localparam logic [WIDTH-1:0] MIN_VAL    = '0;
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic             count_step;   // a count that actually moved the value
    logic             is_max, is_min;

    assign is_max = (bin_q == MAX_VAL);
    assign is_min = (bin_q == MIN_VAL);

    // Next-state: load beats count, count beats hold; tc marks a step past an end.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and a latch is never inferred.
        bin_d      = bin_q;
        tc_d       = 1'b0;
        count_step = 1'b0;
        if (load) begin
            bin_d = load_gray ? gray2bin(load_val) : load_val;
        end else if (en) begin
            if (up) begin
                if (is_max) begin
                    tc_d = 1'b1;
                    if (WRAP != 0) begin
                        bin_d      = MIN_VAL;
                        count_step = 1'b1;
                    end
                end else begin
                    bin_d      = bin_q + ONE;
                    count_step = 1'b1;
                end
            end else begin
                if (is_min) begin
                    tc_d = 1'b1;
                    if (WRAP != 0) begin
                        bin_d      = MAX_VAL;
                        count_step = 1'b1;
                    end
                end else begin
                    bin_d      = bin_q - ONE;
                    count_step = 1'b1;
                end
            end
        end
        gray_d = bin2gray(bin_d);
    end

    // State registers; reset takes effect immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= RESET_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;

    // The end the counter is heading for depends only on the current direction.
    assign at_limit = up ? is_max : is_min;

`ifdef GRAY_CNT_CHECK_EN
    logic [WIDTH-1:0] gray_prev_q;
    logic             step_q;      // last edge was a real count step from a sound state
    logic             err_q, err_d;
    logic             gray_ok;

    assign gray_ok = (gray_q == bin2gray(bin_q));

    // Flag a Gray word that disagrees with the binary state, or that moved by
    // other than one bit on a count step.
    always_comb begin
        err_d = !gray_ok;
        if (step_q && ($countones(gray_q ^ gray_prev_q) != 1)) begin
            err_d = 1'b1;
        end
    end

    // Shadow of the previous Gray word. A step taken from a corrupt word is
    // not distance-checked, so one fault raises err for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_prev_q <= RESET_GRAY;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gray_prev_q <= gray_q;
            step_q      <= count_step && gray_ok;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_counter_pkg.sv
// Directed bench for gray_counter_pkg: a wrapping instance driven from a
// vector table, a saturating instance driven by hand-written sequences,
// plus asynchronous-reset and (with GRAY_CNT_CHECK_EN) error-flag cases.
module tb_gray_counter_pkg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic       load_gray;
    logic [3:0] load_val;

    logic [3:0] gray_w, bin_w, gray_s, bin_s;
    logic       tc_w, al_w, tc_s, al_s;
`ifdef GRAY_CNT_CHECK_EN
    logic       err_w, err_s;
`endif

    int n_pass  = 0;
    int n_total = 0;

    gray_counter_pkg #(.WIDTH(4), .WRAP(1), .RESET_VAL(4'd0)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .gray_out(gray_w), .bin_out(bin_w), .tc(tc_w), .at_limit(al_w)
`ifdef GRAY_CNT_CHECK_EN
        , .err(err_w)
`endif
    );

    gray_counter_pkg #(.WIDTH(4), .WRAP(0), .RESET_VAL(4'd5)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .gray_out(gray_s), .bin_out(bin_s), .tc(tc_s), .at_limit(al_s)
`ifdef GRAY_CNT_CHECK_EN
        , .err(err_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       load_gray;
        logic       en;
        logic       up;
        logic [3:0] load_val;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_tc;
        logic       exp_al;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic lg, input logic e,
                                input logic u, input logic [3:0] lv,
                                input logic [3:0] b, input logic [3:0] g,
                                input logic t, input logic a);
        vec_t v;
        v.load = ld; v.load_gray = lg; v.en = e; v.up = u; v.load_val = lv;
        v.exp_bin = b; v.exp_gray = g; v.exp_tc = t; v.exp_al = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic ld, input logic lg, input logic e,
                         input logic u, input logic [3:0] lv);
        load = ld; load_gray = lg; en = e; up = u; load_val = lv;
    endtask

    // Inputs are driven at the falling edge; outputs are read at the next one.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_s(input string name, input logic [3:0] b, input logic [3:0] g,
                           input logic t, input logic a);
        check({name, " sat bin"}, 32'(bin_s), 32'(b));
        check({name, " sat gray"}, 32'(gray_s), 32'(g));
        check({name, " sat tc"}, 32'(tc_s), 32'(t));
        check({name, " sat at_limit"}, 32'(al_s), 32'(a));
    endtask

    initial begin
        logic [3:0] corrupt;
        logic [3:0] exp_b;

        // Wrap instance: 17 up steps, then down-wrap, Gray load, hold, etc.
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd1,  4'b0001, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd2,  4'b0011, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd3,  4'b0010, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd4,  4'b0110, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd5,  4'b0111, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd6,  4'b0101, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd7,  4'b0100, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd8,  4'b1100, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd9,  4'b1101, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd10, 4'b1111, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd11, 4'b1110, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd12, 4'b1010, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd13, 4'b1011, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd14, 4'b1001, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd15, 4'b1000, 0, 1));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd0,  4'b0000, 1, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd1,  4'b0001, 0, 0));
        // load binary 0, then count down through the wrap
        vecs.push_back(mk(1,0,0,0,4'h0, 4'd0,  4'b0000, 0, 1));
        vecs.push_back(mk(0,0,1,0,4'h0, 4'd15, 4'b1000, 1, 0));
        vecs.push_back(mk(0,0,1,0,4'h0, 4'd14, 4'b1001, 0, 0));
        // Gray load with en high: no extra count step
        vecs.push_back(mk(1,1,1,1,4'b1101, 4'd9, 4'b1101, 0, 0));
        vecs.push_back(mk(0,0,0,1,4'h0, 4'd9,  4'b1101, 0, 0));
        // binary load, then direction changes with no bubble
        vecs.push_back(mk(1,0,0,1,4'd7, 4'd7,  4'b0100, 0, 0));
        vecs.push_back(mk(0,0,1,0,4'h0, 4'd6,  4'b0101, 0, 0));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd7,  4'b0100, 0, 0));
        // load to max never pulses tc; the following up step wraps
        vecs.push_back(mk(1,0,1,1,4'd15, 4'd15, 4'b1000, 0, 1));
        vecs.push_back(mk(0,0,1,1,4'h0, 4'd0,  4'b0000, 1, 0));

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 1, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("reset wrap bin", 32'(bin_w), 32'd0);
        check("reset wrap gray", 32'(gray_w), 32'd0);
        check("reset wrap tc", 32'(tc_w), 32'd0);
        check("reset sat bin", 32'(bin_s), 32'd5);
        check("reset sat gray", 32'(gray_s), 32'b0111);
        check("reset sat tc", 32'(tc_s), 32'd0);
        rst_n = 1'b1;

        // Table-driven vectors on the wrapping instance
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].load, vecs[i].load_gray, vecs[i].en, vecs[i].up, vecs[i].load_val);
            tick();
            check($sformatf("vec%0d bin", i), 32'(bin_w), 32'(vecs[i].exp_bin));
            check($sformatf("vec%0d gray", i), 32'(gray_w), 32'(vecs[i].exp_gray));
            check($sformatf("vec%0d tc", i), 32'(tc_w), 32'(vecs[i].exp_tc));
            check($sformatf("vec%0d at_limit", i), 32'(al_w), 32'(vecs[i].exp_al));
        end

        // Saturating instance: load 14 and push up past the top
        drive(1, 0, 0, 1, 4'd14);
        tick();
        check_s("sat load14", 4'd14, 4'b1001, 0, 0);
        drive(0, 0, 1, 1, 4'h0);
        tick();
        check_s("sat up1", 4'd15, 4'b1000, 0, 1);
        tick();
        check_s("sat up2", 4'd15, 4'b1000, 1, 1);
        tick();
        check_s("sat up3", 4'd15, 4'b1000, 1, 1);
        tick();
        check_s("sat up4", 4'd15, 4'b1000, 1, 1);
        // flipping direction clears at_limit at once and steps down next edge
        drive(0, 0, 1, 0, 4'h0);
        #1;
        check("sat flip at_limit", 32'(al_s), 32'd0);
        @(negedge clk);
        check_s("sat down", 4'd14, 4'b1001, 0, 0);
        // saturate at the bottom, then hold clears tc
        drive(1, 0, 0, 0, 4'd0);
        tick();
        check_s("sat load0", 4'd0, 4'b0000, 0, 1);
        drive(0, 0, 1, 0, 4'h0);
        tick();
        check_s("sat floor", 4'd0, 4'b0000, 1, 1);
        drive(0, 0, 0, 0, 4'h0);
        tick();
        check_s("sat hold", 4'd0, 4'b0000, 0, 1);

        // Asynchronous reset mid-count with a load pending
        drive(1, 0, 0, 1, 4'd7);
        tick();
        check("pre-reset bin", 32'(bin_w), 32'd7);
        drive(1, 0, 1, 1, 4'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async wrap bin", 32'(bin_w), 32'd0);
        check("async wrap gray", 32'(gray_w), 32'd0);
        check("async wrap tc", 32'(tc_w), 32'd0);
        check("async sat bin", 32'(bin_s), 32'd5);
        check("async sat gray", 32'(gray_s), 32'b0111);
        @(negedge clk);
        drive(0, 0, 0, 1, 4'h0);
        rst_n = 1'b1;
        tick();
        check("post-reset wrap bin", 32'(bin_w), 32'd0);
        check("post-reset sat bin", 32'(bin_s), 32'd5);

`ifdef GRAY_CNT_CHECK_EN
        check("err reset", 32'(err_w), 32'd0);
        // full wrap of 16 up steps: err stays low
        drive(0, 0, 1, 1, 4'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("err wrap step%0d", i), 32'(err_w), 32'd0);
        end
        // multi-bit load is exempt from the distance check
        drive(1, 1, 0, 1, 4'b1101);
        tick();
        drive(0, 0, 0, 1, 4'h0);
        tick();
        check("err after load a", 32'(err_w), 32'd0);
        tick();
        check("err after load b", 32'(err_w), 32'd0);
        // corrupt two Gray bits while counting up
        drive(0, 0, 1, 1, 4'h0);
        tick();
        tick();
        exp_b = bin_w;
        corrupt = gray_w ^ 4'b0101;
        force dut_w.gray_q = corrupt;
        #1 release dut_w.gray_q;
        @(negedge clk);
        check("err pulse", 32'(err_w), 32'd1);
        check("err recover bin", 32'(bin_w), 32'(exp_b + 4'd1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("err clear%0d", i), 32'(err_w), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
